// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached command-decoded RAM controller.
// Command encodings travel in the top two bits of each received word.
package spi_ram_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_SET_WADDR = 2'b00,
        CMD_WRITE     = 2'b01,
        CMD_SET_RADDR = 2'b10,
        CMD_READ      = 2'b11
    } cmd_e;

    typedef enum logic {
        StIdle,
        StFull
    } tx_state_e;

endpackage

// File: rtl/spi_ram_ptr.sv
// Single address pointer: range-checked load plus wrap-around advance at MEM_DEPTH-1.
// range_err pulses for the cycle of a rejected load; the pointer keeps its value then.
module spi_ram_ptr #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] ptr,
    output logic              range_err
);

    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d     = ptr_q;
        range_err = load && ({1'b0, load_val} >= DEPTH_EXT);
        if (load) begin
            if (!range_err) begin
                ptr_d = load_val;
            end
        end else if (adv) begin
            ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port RAM behind the SPI slave: write/read pointers, read data
// handed to the transmitter over valid/ready, sticky overrun and address-range flags.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overrun,
    output logic              addr_err
);

    localparam bit AutoInc = (AUTO_INC != 0);

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_val;

    assign cmd      = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload  = din[DATA_W-1:0];
    assign addr_val = payload[ADDR_W-1:0];

    logic is_set_w, is_write, is_set_r, is_read;

    always_comb begin
        is_set_w = 1'b0;
        is_write = 1'b0;
        is_set_r = 1'b0;
        is_read  = 1'b0;
        if (rx_valid) begin
            unique case (cmd)
                CMD_SET_WADDR: is_set_w = 1'b1;
                CMD_WRITE:     is_write = 1'b1;
                CMD_SET_RADDR: is_set_r = 1'b1;
                CMD_READ:      is_read  = 1'b1;
                default:       ;
            endcase
        end
    end

    tx_state_e state_q, state_d;
    logic      read_go;
    logic      read_drop;

    // A READ is only refused when the previous word is still unconsumed.
    assign read_go   = is_read && ((state_q == StIdle) || tx_ready);
    assign read_drop = is_read && (state_q == StFull) && !tx_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (read_go) state_d = StFull;
            StFull: if (tx_ready && !read_go) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_range_err, rd_range_err;

    spi_ram_ptr #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_wr_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (is_set_w),
        .adv       (is_write && AutoInc),
        .load_val  (addr_val),
        .ptr       (wr_ptr),
        .range_err (wr_range_err)
    );

    spi_ram_ptr #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_rd_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (is_set_r),
        .adv       (read_go && AutoInc),
        .load_val  (addr_val),
        .ptr       (rd_ptr),
        .range_err (rd_range_err)
    );

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (rst_n && is_write) begin
            mem[wr_ptr] <= payload;
        end
    end

    logic [DATA_W-1:0] dout_q;
    logic              overrun_q, addr_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dout_q     <= '0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (read_go) begin
                dout_q <= mem[rd_ptr];
            end
            if (read_drop) begin
                overrun_q <= 1'b1;
            end
            if (wr_range_err || rd_range_err) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign dout     = dout_q;
    assign tx_valid = (state_q == StFull);
    assign overrun  = overrun_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: two controllers (auto-increment on / off) share one random stimulus
// stream; a behavioural model queues expected read words, a negedge monitor checks them.
module tb_spi_ram_ctrl;

    localparam int DEPTH = 200;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [9:0] din      = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;

    logic [7:0] dout     [2];
    logic       tx_valid [2];
    logic       overrun  [2];
    logic       addr_err [2];

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .MEM_DEPTH (DEPTH),
        .AUTO_INC  (1)
    ) u_dut_inc (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout[0]),
        .tx_valid (tx_valid[0]),
        .tx_ready (tx_ready),
        .overrun  (overrun[0]),
        .addr_err (addr_err[0])
    );

    spi_ram_ctrl #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .MEM_DEPTH (DEPTH),
        .AUTO_INC  (0)
    ) u_dut_fix (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout[1]),
        .tx_valid (tx_valid[1]),
        .tx_ready (tx_ready),
        .overrun  (overrun[1]),
        .addr_err (addr_err[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state; -1 marks data from a never-written address.
    int exp_q [2][$];
    int m_mem [2][DEPTH];
    bit m_wr  [2][DEPTH];
    int m_wp  [2];
    int m_rp  [2];
    bit m_pend[2];
    bit m_ov  [2];
    bit m_ae  [2];
    int m_dout[2];

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int cmd;
        int pay;
        bit was;
        int d;
        cmd = int'(din[9:8]);
        pay = int'(din[7:0]);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_wp[i]   = 0;
                m_rp[i]   = 0;
                m_pend[i] = 0;
                m_ov[i]   = 0;
                m_ae[i]   = 0;
                m_dout[i] = 0;
                exp_q[i].delete();
            end else begin
                was = m_pend[i];
                if (was && tx_ready) m_pend[i] = 0;
                if (rx_valid) begin
                    case (cmd)
                        0: if (pay >= DEPTH) m_ae[i] = 1; else m_wp[i] = pay;
                        1: begin
                            m_mem[i][m_wp[i]] = pay;
                            m_wr[i][m_wp[i]]  = 1;
                            if (i == 0) m_wp[i] = (m_wp[i] + 1) % DEPTH;
                        end
                        2: if (pay >= DEPTH) m_ae[i] = 1; else m_rp[i] = pay;
                        default: begin
                            if (was && !tx_ready) begin
                                m_ov[i] = 1;
                            end else begin
                                d = m_wr[i][m_rp[i]] ? m_mem[i][m_rp[i]] : -1;
                                m_dout[i] = d;
                                exp_q[i].push_back(d);
                                m_pend[i] = 1;
                                if (i == 0) m_rp[i] = (m_rp[i] + 1) % DEPTH;
                            end
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] c, input logic [7:0] p,
                       input logic rdy);
        rst_n    = r;
        rx_valid = v;
        din      = {c, p};
        tx_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Inputs are stable from just after one posedge to the next, so the negedge sees
    // exactly what the coming edge will act on.
    always @(negedge clk) begin
        int d;
        for (int i = 0; i < 2; i++) begin
            chk("tx_valid", i, int'(tx_valid[i]), int'(m_pend[i]));
            chk("overrun", i, int'(overrun[i]), int'(m_ov[i]));
            chk("addr_err", i, int'(addr_err[i]), int'(m_ae[i]));
            if (m_dout[i] >= 0) chk("dout_hold", i, int'(dout[i]), m_dout[i]);
            if (rst_n && tx_valid[i] && tx_ready) begin
                if (exp_q[i].size() == 0) begin
                    chk("unexpected_tx", i, 1, 0);
                end else begin
                    d = exp_q[i].pop_front();
                    if (d >= 0) chk("rdata", i, int'(dout[i]), d);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) m_dout[i] = 0;
        cyc(0, 0, 2'd0, 8'h00, 0);
        cyc(0, 0, 2'd0, 8'h00, 0);
        // Basic write then read-back
        cyc(1, 1, 2'd0, 8'h10, 0);
        cyc(1, 1, 2'd1, 8'hA5, 0);
        cyc(1, 1, 2'd2, 8'h10, 0);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Burst across the wrap point
        cyc(1, 1, 2'd0, 8'd198, 0);
        cyc(1, 1, 2'd1, 8'd1, 0);
        cyc(1, 1, 2'd1, 8'd2, 0);
        cyc(1, 1, 2'd1, 8'd3, 0);
        cyc(1, 1, 2'd2, 8'd198, 0);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Overrun
        cyc(1, 1, 2'd3, 8'h00, 0);
        cyc(1, 1, 2'd3, 8'h00, 0);
        cyc(1, 0, 2'd0, 8'h00, 0);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Out-of-range address, flag stays sticky
        cyc(1, 1, 2'd2, 8'd250, 0);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Repeated writes to one address
        cyc(1, 1, 2'd0, 8'd5, 0);
        cyc(1, 1, 2'd1, 8'h11, 0);
        cyc(1, 1, 2'd1, 8'h22, 0);
        cyc(1, 1, 2'd2, 8'd5, 0);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Reset with data pending, then memory retention
        cyc(1, 1, 2'd3, 8'h00, 0);
        cyc(0, 0, 2'd0, 8'h00, 0);
        cyc(1, 1, 2'd2, 8'h10, 0);
        cyc(1, 1, 2'd3, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic       v;
            logic [1:0] c;
            logic [7:0] p;
            logic       rdy;
            r   = ($urandom_range(0, 299) != 0);
            v   = ($urandom_range(0, 3) != 0);
            c   = 2'($urandom_range(0, 3));
            p   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255))
                                               : 8'($urandom_range(0, 199));
            rdy = ($urandom_range(0, 2) != 0);
            cyc(r, v, c, p, rdy);
        end
        cyc(1, 0, 2'd0, 8'h00, 1);
        cyc(1, 0, 2'd0, 8'h00, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
